// File: rtl/spi_cmd_slave_if.sv
// ============================================================================
// Module      : spi_cmd_slave_if
// Description : SPI pins plus the decoded-field strobes of spi_cmd_slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_cmd_slave_if #(
  parameter int CMD_W     = 4,
  parameter int ADDR_W    = 4,
  parameter int PAYLOAD_W = 8
);
  logic                 sclk;
  logic                 cs;
  logic                 mosi;
  logic                 miso;
  logic [PAYLOAD_W-1:0] i_tx_payload;
  logic [CMD_W-1:0]     o_cmd;
  logic [ADDR_W-1:0]    o_addr;
  logic [PAYLOAD_W-1:0] o_payload;
  logic                 rx_dv;
  logic                 rd_bypass;
  logic                 rx_addr_dv;

  modport slave (
    input  sclk, cs, mosi, i_tx_payload,
    output miso, o_cmd, o_addr, o_payload, rx_dv, rd_bypass, rx_addr_dv
  );

  modport master (
    output sclk, cs, mosi, i_tx_payload,
    input  miso, o_cmd, o_addr, o_payload, rx_dv, rd_bypass, rx_addr_dv
  );
endinterface

`default_nettype wire

// File: rtl/spi_cmd_slave.sv
// ============================================================================
// Module      : spi_cmd_slave
// Description : Oversampled SPI mode-0 slave decoding {cmd, addr, payload}
//               frames, with early address strobe and read-data return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cmd_slave #(
  parameter int               CMD_W     = 4,
  parameter int               ADDR_W    = 4,
  parameter int               PAYLOAD_W = 8,
  parameter logic [CMD_W-1:0] CMD_NOP   = 4'd0,
  parameter logic [CMD_W-1:0] CMD_SET   = 4'd1,
  parameter logic [CMD_W-1:0] CMD_READ  = 4'd2
) (
  input  wire logic      sysclk,
  input  wire logic      rst_n,
  spi_cmd_slave_if.slave bus
);

  localparam int FRAME_W = CMD_W + ADDR_W + PAYLOAD_W;
  localparam int c_hdr_w = CMD_W + ADDR_W;
  localparam int c_sr_w  = (c_hdr_w > PAYLOAD_W) ? c_hdr_w : PAYLOAD_W;
  localparam int c_cnt_w = $clog2(FRAME_W + 1);

  localparam logic [c_cnt_w-1:0] c_hdr_last   = c_cnt_w'(c_hdr_w - 1);
  localparam logic [c_cnt_w-1:0] c_frame_last = c_cnt_w'(FRAME_W - 1);
  localparam logic [c_cnt_w-1:0] c_hdr_cnt    = c_cnt_w'(c_hdr_w);
  // A READ code aliased onto NOP/SET would make every write a read; never bypass then.
  localparam bit c_read_ok = (CMD_READ != CMD_NOP) && (CMD_READ != CMD_SET);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // wait for cs high before accepting a frame
    ST_ARMED = 2'd1,  // cs high, wait for falling edge
    ST_RX    = 2'd2,  // shifting frame bits
    ST_DONE  = 2'd3   // frame complete, ignore bits until cs high
  } state_t;

  state_t r_state, w_state_nxt;

  logic r_sclk_meta, r_sclk_sync, r_sclk_dly;
  logic r_cs_meta, r_cs_sync;
  logic r_mosi_meta, r_mosi_sync;

  logic [c_sr_w-1:0]    r_rx_sr;
  logic [PAYLOAD_W-1:0] r_tx_sr;
  logic [c_cnt_w-1:0]   r_bit_cnt;
  logic                 r_hdr_pend, r_frame_pend;

  logic [CMD_W-1:0]     r_cmd;
  logic [ADDR_W-1:0]    r_addr;
  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_rx_dv, r_rx_addr_dv, r_rd_bypass;

  logic w_sclk_rise, w_start, w_abort, w_capture;

  assign w_sclk_rise = r_sclk_sync & ~r_sclk_dly;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_dly  <= 1'b0;
      r_cs_meta   <= 1'b0;
      r_cs_sync   <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_sclk_meta <= bus.sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_dly  <= r_sclk_sync;
      r_cs_meta   <= bus.cs;
      r_cs_sync   <= r_cs_meta;
      r_mosi_meta <= bus.mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE:  if (r_cs_sync) w_state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!r_cs_sync) begin
          w_start     = 1'b1;
          w_state_nxt = ST_RX;
        end
      end
      ST_RX: begin
        if (r_cs_sync) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_ARMED;
        end else if (w_sclk_rise) begin
          w_capture = 1'b1;
          if (r_bit_cnt == c_frame_last) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  if (r_cs_sync) w_state_nxt = ST_ARMED;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_rx_sr      <= '0;
      r_tx_sr      <= '0;
      r_bit_cnt    <= '0;
      r_hdr_pend   <= 1'b0;
      r_frame_pend <= 1'b0;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_payload    <= '0;
      r_rx_dv      <= 1'b0;
      r_rx_addr_dv <= 1'b0;
      r_rd_bypass  <= 1'b0;
    end else begin
      r_rx_dv      <= 1'b0;
      r_rx_addr_dv <= 1'b0;
      r_hdr_pend   <= 1'b0;
      r_frame_pend <= 1'b0;

      if (w_abort || w_start) begin
        r_bit_cnt <= '0;
        r_rx_sr   <= '0;
      end else if (w_capture) begin
        r_rx_sr      <= {r_rx_sr[c_sr_w-2:0], r_mosi_sync};
        r_bit_cnt    <= r_bit_cnt + 1'b1;
        r_hdr_pend   <= (r_bit_cnt == c_hdr_last);
        r_frame_pend <= (r_bit_cnt == c_frame_last);
      end

      // Top answers rx_addr_dv combinationally; its data is latched at the end of that cycle.
      if (w_abort) begin
        r_tx_sr <= '0;
      end else if (r_rx_addr_dv) begin
        r_tx_sr <= r_rd_bypass ? bus.i_tx_payload : '0;
      end else if (w_capture && (r_bit_cnt >= c_hdr_cnt)) begin
        r_tx_sr <= {r_tx_sr[PAYLOAD_W-2:0], 1'b0};
      end

      if (r_hdr_pend) begin
        r_cmd        <= r_rx_sr[c_hdr_w-1 -: CMD_W];
        r_addr       <= r_rx_sr[ADDR_W-1:0];
        r_rx_addr_dv <= 1'b1;
        r_rd_bypass  <= c_read_ok && (r_rx_sr[c_hdr_w-1 -: CMD_W] == CMD_READ);
      end

      if (r_frame_pend) begin
        r_payload <= r_rx_sr[PAYLOAD_W-1:0];
        r_rx_dv   <= 1'b1;
      end

      if (r_cs_sync) r_rd_bypass <= 1'b0;
    end
  end

  assign bus.miso       = ~r_cs_sync & r_tx_sr[PAYLOAD_W-1];
  assign bus.o_cmd      = r_cmd;
  assign bus.o_addr     = r_addr;
  assign bus.o_payload  = r_payload;
  assign bus.rx_dv      = r_rx_dv;
  assign bus.rx_addr_dv = r_rx_addr_dv;
  assign bus.rd_bypass  = r_rd_bypass;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_slave.sv
// ============================================================================
// Module      : tb_spi_cmd_slave
// Description : Directed SPI mode-0 frames against spi_cmd_slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_cmd_slave;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_rx_dv  = 0;
  int n_addr   = 0;

  spi_cmd_slave_if #(.CMD_W(4), .ADDR_W(4), .PAYLOAD_W(8)) bus ();

  spi_cmd_slave dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (bus.rx_dv)      n_rx_dv <= n_rx_dv + 1;
    if (bus.rx_addr_dv) n_addr  <= n_addr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // One mode-0 bit: MOSI set while sclk low, MISO sampled just before the rising edge.
  task automatic spi_bit(input logic b, output logic m);
    bus.mosi = b;
    wait_cyc(4);
    m = bus.miso;
    bus.sclk = 1'b1;
    wait_cyc(4);
    bus.sclk = 1'b0;
  endtask

  // Drop cs and clock nbits; bits past 16 send 1s. cs is left low.
  task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [15:0] mv);
    logic m;
    mv = '0;
    bus.cs = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < nbits; i++) begin
      spi_bit((i < 16) ? w[15-i] : 1'b1, m);
      if (i < 16) mv[15-i] = m;
    end
    wait_cyc(8);
  endtask

  task automatic cs_release();
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    wait_cyc(6);
  endtask

  initial begin
    logic [15:0] mv;
    int          dv0, ad0;

    bus.sclk = 1'b0;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    bus.i_tx_payload = 8'h00;
    wait_cyc(5);
    chk("rst_cmd",     32'(bus.o_cmd), 32'h0);
    chk("rst_addr",    32'(bus.o_addr), 32'h0);
    chk("rst_payload", 32'(bus.o_payload), 32'h0);
    chk("rst_rx_dv",   32'(bus.rx_dv), 32'h0);
    chk("rst_addr_dv", 32'(bus.rx_addr_dv), 32'h0);
    chk("rst_bypass",  32'(bus.rd_bypass), 32'h0);
    chk("rst_miso",    32'(bus.miso), 32'h0);
    rst_n = 1'b1;
    wait_cyc(6);

    // SET 0x1_3_A4
    dv0 = n_rx_dv; ad0 = n_addr;
    spi_frame(16'h13A4, 16, mv);
    chk("set_addr_dv_cnt", 32'(n_addr - ad0), 32'd1);
    chk("set_rx_dv_cnt",   32'(n_rx_dv - dv0), 32'd1);
    chk("set_cmd",         32'(bus.o_cmd), 32'h1);
    chk("set_addr",        32'(bus.o_addr), 32'h3);
    chk("set_payload",     32'(bus.o_payload), 32'hA4);
    chk("set_bypass",      32'(bus.rd_bypass), 32'h0);
    chk("set_miso",        32'(mv), 32'h0);
    cs_release();

    // READ cmd 2 addr 5 returning 0x5A
    bus.i_tx_payload = 8'h5A;
    dv0 = n_rx_dv; ad0 = n_addr;
    spi_frame(16'h2500, 16, mv);
    chk("rd_bypass_hi",   32'(bus.rd_bypass), 32'h1);
    chk("rd_addr_dv_cnt", 32'(n_addr - ad0), 32'd1);
    chk("rd_rx_dv_cnt",   32'(n_rx_dv - dv0), 32'd1);
    chk("rd_cmd",         32'(bus.o_cmd), 32'h2);
    chk("rd_addr",        32'(bus.o_addr), 32'h5);
    chk("rd_payload",     32'(bus.o_payload), 32'h00);
    chk("rd_miso",        32'(mv), 32'h005A);
    cs_release();
    chk("rd_bypass_clr",  32'(bus.rd_bypass), 32'h0);
    bus.i_tx_payload = 8'h00;

    // Abort before header complete: no strobes at all
    dv0 = n_rx_dv; ad0 = n_addr;
    spi_frame(16'h3C00, 5, mv);
    cs_release();
    chk("ab5_addr_dv_cnt", 32'(n_addr - ad0), 32'd0);
    chk("ab5_rx_dv_cnt",   32'(n_rx_dv - dv0), 32'd0);
    chk("ab5_cmd",         32'(bus.o_cmd), 32'h2);

    // Abort after 10 bits: header strobed, payload untouched
    dv0 = n_rx_dv; ad0 = n_addr;
    spi_frame(16'h1933, 10, mv);
    cs_release();
    chk("ab10_addr_dv_cnt", 32'(n_addr - ad0), 32'd1);
    chk("ab10_rx_dv_cnt",   32'(n_rx_dv - dv0), 32'd0);
    chk("ab10_payload",     32'(bus.o_payload), 32'h00);
    chk("ab10_miso_idle",   32'(bus.miso), 32'h0);
    dv0 = n_rx_dv;
    spi_frame(16'h17FE, 16, mv);
    cs_release();
    chk("post_ab_rx_dv_cnt", 32'(n_rx_dv - dv0), 32'd1);
    chk("post_ab_addr",      32'(bus.o_addr), 32'h7);
    chk("post_ab_payload",   32'(bus.o_payload), 32'hFE);

    // Back-to-back NOP then SET
    dv0 = n_rx_dv;
    spi_frame(16'h0611, 16, mv);
    cs_release();
    chk("nop_rx_dv_cnt", 32'(n_rx_dv - dv0), 32'd1);
    chk("nop_cmd",       32'(bus.o_cmd), 32'h0);
    chk("nop_addr",      32'(bus.o_addr), 32'h6);
    chk("nop_payload",   32'(bus.o_payload), 32'h11);
    spi_frame(16'h1C3B, 16, mv);
    cs_release();
    chk("b2b_rx_dv_cnt", 32'(n_rx_dv - dv0), 32'd2);
    chk("b2b_cmd",       32'(bus.o_cmd), 32'h1);
    chk("b2b_addr",      32'(bus.o_addr), 32'hC);
    chk("b2b_payload",   32'(bus.o_payload), 32'h3B);

    // Unknown command decodes like NOP, no bypass
    spi_frame(16'hF299, 16, mv);
    chk("unk_bypass", 32'(bus.rd_bypass), 32'h0);
    chk("unk_cmd",    32'(bus.o_cmd), 32'hF);
    chk("unk_miso",   32'(mv), 32'h0);
    cs_release();

    // Reset mid-frame, then bits without a fresh cs fall are ignored
    spi_frame(16'h2800, 6, mv);
    rst_n = 1'b0;
    wait_cyc(3);
    chk("mrst_cmd",     32'(bus.o_cmd), 32'h0);
    chk("mrst_addr",    32'(bus.o_addr), 32'h0);
    chk("mrst_payload", 32'(bus.o_payload), 32'h0);
    chk("mrst_bypass",  32'(bus.rd_bypass), 32'h0);
    chk("mrst_miso",    32'(bus.miso), 32'h0);
    rst_n = 1'b1;
    wait_cyc(4);
    dv0 = n_rx_dv; ad0 = n_addr;
    spi_frame(16'h1234, 16, mv);
    chk("mrst_no_rx_dv",   32'(n_rx_dv - dv0), 32'd0);
    chk("mrst_no_addr_dv", 32'(n_addr - ad0), 32'd0);
    cs_release();
    spi_frame(16'h14C3, 16, mv);
    cs_release();
    chk("mrst_next_rx_dv", 32'(n_rx_dv - dv0), 32'd1);
    chk("mrst_next_addr",  32'(bus.o_addr), 32'h4);
    chk("mrst_next_pl",    32'(bus.o_payload), 32'hC3);

    // 20 extra sclk pulses in the same cs window
    dv0 = n_rx_dv; ad0 = n_addr;
    spi_frame(16'h1A5C, 36, mv);
    chk("xtra_rx_dv_cnt",   32'(n_rx_dv - dv0), 32'd1);
    chk("xtra_addr_dv_cnt", 32'(n_addr - ad0), 32'd1);
    chk("xtra_cmd",         32'(bus.o_cmd), 32'h1);
    chk("xtra_addr",        32'(bus.o_addr), 32'hA);
    chk("xtra_payload",     32'(bus.o_payload), 32'h5C);
    cs_release();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
